uart_core: RTL and testbench
============================

// Module: uart_core
// PURPOSE
//   UART transmitter and receiver with internal loopback (tx line feeds rx), self-checking serial core.
//   Shared programmable baud tick at 16x oversampling; frame = 1 start, DBIT data LSB-first, 1 stop, no parity.
//   Serialises din on tx_start; reports completion via tx_done_tick, received word on dout with rx_done_tick.
// PARAMETERS
//   DBIT     8   data bits per frame
//   SB_TICK  16  oversampling ticks in stop bit (16=1, 24=1.5, 32=2 stop bits)
// PORTS
//   clk           in   1      system clock, all logic on rising edge
//   rst           in   1      reset, asynchronous, active-low
//   din           in   DBIT   transmit word, sampled on accepted tx_start
//   dvsr          in   11     baud divisor; tick period = dvsr+1 clocks
//   tx_start      in   1      request transmit; level, accepted only when TX idle
//   tx_done_tick  out  1      1-cycle pulse at end of TX stop bit
//   rx_done_tick  out  1      1-cycle pulse when RX frame complete
//   dout          out  DBIT   last received word, held until next frame
// BEHAVIOUR
//   Reset (rst=0, async): counters/shift regs 0, TX/RX FSMs IDLE, serial line 1, all outputs 0.
//   Baud gen: 11-bit counter 0..dvsr, wraps to 0; s_tick=1 for one clk when counter==dvsr.
//     dvsr=66 -> tick every 67 clks, bit = 16 ticks = 1072 clks. dvsr change takes effect at next wrap.
//   TX FSM (IDLE,START,DATA,STOP), tick count s (4b), bit count n (log2 DBIT), shift reg b:
//     IDLE: line=1; tx_start=1 -> latch din into b, s=0, go START. tx_start ignored in other states.
//     START: line=0 for 16 ticks -> DATA, s=0, n=0.
//     DATA: line=b[0]; after 16 ticks b>>=1, n++; after bit DBIT-1 -> STOP.
//     STOP: line=1 for SB_TICK ticks -> IDLE, tx_done_tick=1 that cycle.
//     tx_start held high through tx_done -> next frame starts on following cycle (back-to-back).
//   RX FSM (IDLE,START,DATA,STOP) on looped line, registered once before FSM:
//     IDLE: line=0 -> START, s=0.
//     START: at s==7 (mid start bit) -> DATA, s=0,n=0; line checked at s==7, if 1 (glitch) -> IDLE.
//     DATA: at s==15 sample line into MSB of shift reg (shift right), n++; after DBIT bits -> STOP.
//     STOP: after SB_TICK ticks -> IDLE, dout<=shift reg, rx_done_tick=1 one cycle.
//   Ordering: rx_done_tick precedes tx_done_tick by ~half bit; dout valid same cycle as rx_done_tick.
//   dout/din width DBIT; dvsr=0 -> tick every clock (legal). Reset mid-frame aborts both FSMs, no done pulses.
// TESTING
//   rst=0 2 clks, release, no tx_start -> dout=0, no done pulses, line idle high for 20000 clks.
//   dvsr=66, din=8'h56, tx_start 1 clk -> rx_done_tick ~9.5*1072 clks later, dout=8'h56; tx_done_tick after.
//   20 random din bytes, each sent after previous tx_done_tick -> every dout==din; each done pulse 1 clk wide.
//   din=8'h00 then 8'hFF -> dout=8'h00 then 8'hFF (start/stop framing at extremes).
//   tx_start pulsed again mid-frame with new din -> ignored; dout = original byte only.
//   Assert rst mid-DATA -> both FSMs IDLE immediately, no rx_done_tick; next frame received correctly.

Source files
------------

// File: rtl/uart_core_if.sv
// Host-side bus of the UART core: transmit request/data, baud divisor, completion pulses and received word.
interface uart_core_if #(parameter int unsigned DBIT = 8);
    logic [DBIT-1:0] din;
    logic [10:0]     dvsr;
    logic            tx_start;
    logic            tx_done_tick;
    logic            rx_done_tick;
    logic [DBIT-1:0] dout;

    modport master (output din, dvsr, tx_start, input tx_done_tick, rx_done_tick, dout);
    modport slave  (input din, dvsr, tx_start, output tx_done_tick, rx_done_tick, dout);
endinterface

// File: rtl/uart_core.sv
// UART transmitter and receiver sharing a 16x-oversampling baud tick; the tx line is looped back into rx.
module uart_core #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input logic        clk,
    input logic        rst,
    uart_core_if.slave bus
);
    localparam int unsigned CW = 11;
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [CW-1:0]   cnt_q, cnt_d, dvsr_q, dvsr_d;
    logic            s_tick;
    state_e          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [SW-1:0]   tx_s_q, tx_s_d, rx_s_q, rx_s_d;
    logic [NW-1:0]   tx_n_q, tx_n_d, rx_n_q, rx_n_d;
    logic [DBIT-1:0] tx_b_q, tx_b_d, rx_b_q, rx_b_d;
    logic            tx_line_q, tx_line_d, rx_sync_q;
    logic            tx_done_q, tx_done_d, rx_done_q, rx_done_d;
    logic [DBIT-1:0] dout_q, dout_d;

    // Divisor is captured only at wrap so a mid-period change cannot skip past the compare value.
    always_comb begin
        s_tick = (cnt_q == dvsr_q);
        cnt_d  = s_tick ? '0 : cnt_q + CW'(1);
        dvsr_d = s_tick ? bus.dvsr : dvsr_q;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_b_d     = tx_b_q;
        tx_line_d  = 1'b1;
        tx_done_d  = 1'b0;
        case (tx_state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    tx_b_d     = bus.din;
                    tx_s_d     = '0;
                    tx_state_d = START;
                end
            end
            START: begin
                tx_line_d = 1'b0;
                if (s_tick) begin
                    if (tx_s_q == SW'(15)) begin
                        tx_s_d     = '0;
                        tx_n_d     = '0;
                        tx_state_d = DATA;
                    end else begin
                        tx_s_d = tx_s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                tx_line_d = tx_b_q[0];
                if (s_tick) begin
                    if (tx_s_q == SW'(15)) begin
                        tx_s_d = '0;
                        tx_b_d = tx_b_q >> 1;
                        if (tx_n_q == NW'(DBIT - 1)) tx_state_d = STOP;
                        else                         tx_n_d     = tx_n_q + NW'(1);
                    end else begin
                        tx_s_d = tx_s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tx_s_q == SW'(SB_TICK - 1)) begin
                        tx_state_d = IDLE;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_s_d = tx_s_q + SW'(1);
                    end
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // Receiver samples mid-bit: 8 ticks into the start bit, then every 16 ticks.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_n_d     = rx_n_q;
        rx_b_d     = rx_b_q;
        rx_done_d  = 1'b0;
        dout_d     = dout_q;
        case (rx_state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    rx_s_d     = '0;
                    rx_state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (rx_s_q == SW'(7)) begin
                        rx_s_d     = '0;
                        rx_n_d     = '0;
                        rx_state_d = rx_sync_q ? IDLE : DATA;
                    end else begin
                        rx_s_d = rx_s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (rx_s_q == SW'(15)) begin
                        rx_s_d = '0;
                        rx_b_d = {rx_sync_q, rx_b_q[DBIT-1:1]};
                        if (rx_n_q == NW'(DBIT - 1)) rx_state_d = STOP;
                        else                         rx_n_d     = rx_n_q + NW'(1);
                    end else begin
                        rx_s_d = rx_s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (rx_s_q == SW'(SB_TICK - 1)) begin
                        rx_state_d = IDLE;
                        rx_done_d  = 1'b1;
                        dout_d     = rx_b_q;
                    end else begin
                        rx_s_d = rx_s_q + SW'(1);
                    end
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            dvsr_q     <= '0;
            tx_state_q <= IDLE;
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_b_q     <= '0;
            tx_line_q  <= 1'b1;
            tx_done_q  <= 1'b0;
            rx_sync_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_s_q     <= '0;
            rx_n_q     <= '0;
            rx_b_q     <= '0;
            rx_done_q  <= 1'b0;
            dout_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            dvsr_q     <= dvsr_d;
            tx_state_q <= tx_state_d;
            tx_s_q     <= tx_s_d;
            tx_n_q     <= tx_n_d;
            tx_b_q     <= tx_b_d;
            tx_line_q  <= tx_line_d;
            tx_done_q  <= tx_done_d;
            rx_sync_q  <= tx_line_q;
            rx_state_q <= rx_state_d;
            rx_s_q     <= rx_s_d;
            rx_n_q     <= rx_n_d;
            rx_b_q     <= rx_b_d;
            rx_done_q  <= rx_done_d;
            dout_q     <= dout_d;
        end
    end

    assign bus.tx_done_tick = tx_done_q;
    assign bus.rx_done_tick = rx_done_q;
    assign bus.dout         = dout_q;
endmodule

// File: tb/tb_uart_core.sv
// Loopback UART bench: expected bytes and frame timing come from a queue model and bit-period arithmetic.
module tb_uart_core;
    localparam int unsigned DBIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_core_if #(.DBIT(DBIT)) bus ();
    uart_core #(.DBIT(DBIT), .SB_TICK(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rx_cnt = 0, tx_cnt = 0, rx_t = 0, tx_t = 0;
    logic rx_prev = 1'b0, tx_prev = 1'b0;
    logic [DBIT-1:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rx_done_tick must deliver the oldest accepted byte; pulses one cycle wide.
    always @(negedge clk) begin
        logic [DBIT-1:0] e;
        if (rx_prev) check("rx_pulse_width", 32'(bus.rx_done_tick), 0);
        if (tx_prev) check("tx_pulse_width", 32'(bus.tx_done_tick), 0);
        if (bus.rx_done_tick === 1'b1) begin
            rx_cnt++;
            rx_t = cyc;
            if (exp_q.size() == 0) begin
                check("rx_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("dout", 32'(bus.dout), 32'(e));
            end
        end
        if (bus.tx_done_tick === 1'b1) begin
            tx_cnt++;
            tx_t = cyc;
        end
        rx_prev = bus.rx_done_tick;
        tx_prev = bus.tx_done_tick;
    end

    task automatic wait_cnt(input bit is_rx, input int start, input int limit, input string tag);
        int k = 0;
        while (((is_rx ? rx_cnt : tx_cnt) == start) && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
        if ((is_rx ? rx_cnt : tx_cnt) == start) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic set_dvsr(input int unsigned dv);
        bus.dvsr = 11'(dv);
        repeat (80) @(negedge clk);
    endtask

    // One frame: rx completes ~152 ticks after the start request, tx ~8 ticks later.
    task automatic frame(input logic [DBIT-1:0] d, input int unsigned dv, input string tag);
        int p, rx0, tx0, t0, lat, gap;
        p = int'(dv) + 1;
        set_dvsr(dv);
        rx0 = rx_cnt;
        tx0 = tx_cnt;
        @(negedge clk);
        bus.din = d;
        bus.tx_start = 1'b1;
        exp_q.push_back(d);
        t0 = cyc;
        @(negedge clk);
        bus.tx_start = 1'b0;
        wait_cnt(1'b1, rx0, 200 * p + 50, {tag, "_rx"});
        lat = rx_t - t0;
        check({tag, "_rx_latency_ok"}, 32'(lat >= 151 * p && lat <= 153 * p + 8), 1);
        wait_cnt(1'b0, tx0, 20 * p + 50, {tag, "_tx"});
        gap = tx_t - rx_t;
        check({tag, "_rx_before_tx_ok"}, 32'(gap >= 7 * p - 4 && gap <= 8 * p + 1), 1);
        check({tag, "_rx_count"}, 32'(rx_cnt - rx0), 1);
    endtask

    initial begin
        int rx0, tx0, low;
        bus.din = '0;
        bus.dvsr = 11'd66;
        bus.tx_start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_dout", 32'(bus.dout), 0);
        check("reset_rx_done", 32'(bus.rx_done_tick), 0);
        check("reset_tx_done", 32'(bus.tx_done_tick), 0);
        check("reset_line", 32'(dut.tx_line_q), 1);
        rst = 1'b1;

        low = 0;
        repeat (20000) begin
            @(negedge clk);
            if (dut.tx_line_q !== 1'b1) low++;
        end
        check("idle_line_low_cycles", 32'(low), 0);
        check("idle_rx_pulses", 32'(rx_cnt), 0);
        check("idle_tx_pulses", 32'(tx_cnt), 0);
        check("idle_dout", 32'(bus.dout), 0);

        frame(8'h56, 66, "f56");
        frame(8'h00, 2, "f00");
        frame(8'hFF, 2, "fff");

        // Back-to-back: tx_start held across tx_done, next byte latched the following cycle.
        set_dvsr(1);
        rx0 = rx_cnt;
        tx0 = tx_cnt;
        @(negedge clk);
        bus.din = 8'h00;
        bus.tx_start = 1'b1;
        exp_q.push_back(8'h00);
        wait_cnt(1'b0, tx0, 400, "b2b_first");
        bus.din = 8'hFF;
        exp_q.push_back(8'hFF);
        repeat (2) @(negedge clk);
        bus.tx_start = 1'b0;
        wait_cnt(1'b0, tx0 + 1, 400, "b2b_second");
        check("b2b_rx_count", 32'(rx_cnt - rx0), 2);

        // A start request mid-frame must be ignored.
        set_dvsr(3);
        rx0 = rx_cnt;
        tx0 = tx_cnt;
        @(negedge clk);
        bus.din = 8'hA5;
        bus.tx_start = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (300) @(negedge clk);
        bus.din = 8'h3C;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        wait_cnt(1'b1, rx0, 1000, "ign_rx");
        wait_cnt(1'b0, tx0, 1000, "ign_tx");
        repeat (800) @(negedge clk);
        check("ign_rx_count", 32'(rx_cnt - rx0), 1);
        check("ign_tx_count", 32'(tx_cnt - tx0), 1);
        check("ign_dout", 32'(bus.dout), 32'h A5);

        // Reset in the middle of the data bits aborts both directions silently.
        set_dvsr(3);
        rx0 = rx_cnt;
        tx0 = tx_cnt;
        @(negedge clk);
        bus.din = 8'h5A;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (16 * 4 * 3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_line", 32'(dut.tx_line_q), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        check("rst_rx_count", 32'(rx_cnt - rx0), 0);
        check("rst_tx_count", 32'(tx_cnt - tx0), 0);
        frame(8'hC3, 3, "post_rst");

        for (int i = 0; i < 20; i++) begin
            frame(8'($urandom), $urandom_range(0, 4), $sformatf("rnd%0d", i));
        end
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
